dbuf2ddr: RTL
=============

# dbuf2ddr

Read-back engine: the write-back counterpart of the DDR-to-data-buffer loader. After a layer pass, it walks one 4-PE group's data buffers in the same address and unit layout the loader writes, issues buffer reads, and streams each word to the DDR write channel over a valid/ready handshake. An internal credit-controlled FIFO absorbs DDR backpressure without stalling the fixed-latency buffer read pipe.

## Interface
Parameters:
- BUF_DEPTH, 256, words per PE data buffer
- ADDR_W, bw(BUF_DEPTH), buffer address width
- PE_NUM, 32, PEs; groups of 4, PE_NUM/4 groups
- RD_LAT, 2, fixed buffer read latency (rd_en to rd_data), 1..4
- FIFO_DEPTH, 8, output FIFO entries; must be ≥ RD_LAT+2

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse; honored only in IDLE
- done  out  1  high when idle or finished; reset 1
- conf_mode  in  4  bit0: 1 = FC, 0 = CONV; other bits ignored
- conf_ch_num  in  4  channels-1 (CONV) / last address (FC)
- conf_row_num  in  4  rows-1 (CONV)
- conf_pix_num  in  4  pixels per row-1 (CONV)
- conf_grp  in  bw(PE_NUM/4)  4-PE group to read
- dbuf_rd_addr  out  ADDR_W  buffer read address; reset 0
- dbuf_rd_en  out  PE_NUM  one-hot read enable; reset 0
- dbuf_rd_data  in  [3:0][DATA_W*BATCH]  per-unit read data of the selected group, valid RD_LAT cycles after rd_en
- ddr_data  out  DDR_W  write data; reset 0
- ddr_valid  out  1  reset 0
- ddr_ready  in  1  DDR write channel accepts when valid&&ready

DDR_W equals DATA_W*BATCH; the word is copied unchanged, batch i in bits [DATA_W*i +: DATA_W].

## Operation
- Config is latched on an accepted start; later changes have no effect on the running pass.
- FSM: IDLE → RUN on start (done falls the next cycle). RUN → DRAIN once the last read is issued. DRAIN → IDLE when in-flight=0, FIFO empty, and the final DDR beat is accepted. done rises the cycle after that beat.
- CONV order: row, then pixel, then channel innermost. Address = {ch[ADDR_W-5:0], row[1], pix[3:1]}; unit u = {row[0], pix[0]}. Words = (ch+1)(pix+1)(row+1).
- FC order: address 0..conf_ch_num, unit 0. Words = conf_ch_num+1.
- dbuf_rd_en bit conf_grp*4+u is high for one cycle per issued read; all other bits are 0.
- Credit rule: issue only when fifo_count + inflight < FIFO_DEPTH. inflight counts issued reads with no data yet returned, from 0..RD_LAT. Data therefore never meets a full FIFO, so no data is dropped.
- Unit select is delayed RD_LAT cycles alongside rd_en. The returning word is muxed from dbuf_rd_data[u_d] and pushed to the FIFO.
- FIFO is first-word-fall-through. ddr_data is the FIFO head and ddr_valid = !empty. Pop on valid&&ready. Push and pop in the same cycle leave the count unchanged.
- ddr_valid, once high, stays high and ddr_data stays stable until accepted.
- start in RUN or DRAIN is ignored.
- Asynchronous rst at any point: FSM to IDLE, counters and FIFO cleared, in-flight data discarded, outputs to their reset values.

## Timing
- First read at cycle S+1 (S = start cycle). First ddr_valid at S+1+RD_LAT+1 (one cycle of FIFO write).
- With ready held high, one word per cycle sustained. Total pass = words + RD_LAT + 2 cycles from start to done high.
- ready low for N cycles: issue stops after the FIFO_DEPTH credit is exhausted and resumes the cycle after credit frees.

## Structure
- DATA_W, BATCH, DDR_W and bw() are taken from the GLOBAL_PARAM package. Add the FSM enum type dbuf2ddr_state_t (IDLE, RUN, DRAIN) to GLOBAL_PARAM.
- Sub-module sync_fifo_fwft (WIDTH, DEPTH; push, pop, head, empty, full, count), reusable elsewhere.
- Top level holds the address walker, the credit counter and the RD_LAT delay line.

## Test plan
- Reset: assert rst mid-pass → done=1, ddr_valid=0, dbuf_rd_en=0 immediately. A following start yields a clean pass.
- FC, ch_num=5, grp=2, ready=1, RD_LAT=2: addresses 0..5 on dbuf_rd_en bit 8 → 6 DDR beats equal to the unit-0 data, in order. done rises 10 cycles after start.
- CONV, ch=1, pix=1, row=1: 8 reads. Sequence is (addr,unit) = (0,0),(16,0),(0,1),(16,1),(0,2),(16,2),(0,3),(16,3) → 8 beats matching.
- Backpressure: FC 32 words, ready random 30%. No beat lost or duplicated, inflight+count never exceeds 8, and ddr_data is stable while valid && !ready.
- Start while busy: a second start pulse mid-RUN is ignored. Word count is unchanged and done rises once.
- Config change mid-pass: altering conf_ch_num after start does not alter the 6-word FC pass.

Source files
------------

// File: rtl/dbuf2ddr_pkg.sv
// Shared definitions for the data-buffer read-back path.
//   DATA_W / BATCH / DDR_W : word geometry; one DDR beat carries BATCH
//                            samples of DATA_W bits, batch i at [DATA_W*i +: DATA_W]
//   bw()                   : bit width needed to index/count x items (min 1)
//   dbuf2ddr_state_t       : read-back engine FSM states
package dbuf2ddr_pkg;

  localparam int DATA_W = 16;
  localparam int BATCH  = 4;
  localparam int DDR_W  = DATA_W * BATCH;

  function automatic int bw(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dbuf2ddr_state_t;

endpackage

// File: rtl/dbuf2ddr_sync_fifo.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO.
//   clk, rst        : clock, asynchronous active-high reset (pointers/count only)
//   push, push_data : write request and word
//   pop             : consume the head word (ignored when empty)
//   head            : current head word, valid whenever !empty
//   empty, full     : status flags
//   count           : number of stored words, 0..DEPTH
// A push while full is accepted only when a pop frees the head slot in the
// same cycle. Push and pop together leave count unchanged.
module sync_fifo_fwft
  import dbuf2ddr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic                    empty,
  output logic                    full,
  output logic [bw(DEPTH+1)-1:0]  count
);

  localparam int PTR_W = bw(DEPTH);
  localparam int CNT_W = bw(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is pure data: never reset, only written on push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dbuf2ddr.sv
// dbuf2ddr: data-buffer to DDR read-back engine.
// Walks one 4-PE group's data buffers in the loader's address/unit layout,
// issues reads into the fixed-latency buffer pipe and streams each returned
// word to the DDR write channel through a FWFT FIFO. Reads are only issued
// while FIFO occupancy plus reads still in the pipe is below FIFO_DEPTH, so
// returning data always finds room and DDR backpressure never stalls the pipe.
//   clk, rst            : clock, asynchronous active-high reset
//   start, done         : pass launch pulse (honored in IDLE) / idle flag
//   conf_mode[0]        : 1 = FC walk, 0 = CONV walk (other bits ignored)
//   conf_ch_num         : channels-1 (CONV) or last address (FC)
//   conf_row_num        : rows-1 (CONV)
//   conf_pix_num        : pixels per row-1 (CONV)
//   conf_grp            : 4-PE group to read
//   dbuf_rd_addr/en     : buffer read address and one-hot PE read enable
//   dbuf_rd_data        : per-unit read data of the group, RD_LAT after rd_en
//   ddr_data/valid/ready: DDR write channel
module dbuf2ddr
  import dbuf2ddr_pkg::*;
#(
  parameter int BUF_DEPTH  = 256,
  parameter int ADDR_W     = bw(BUF_DEPTH),
  parameter int PE_NUM     = 32,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        done,
  input  logic [3:0]                  conf_mode,
  input  logic [3:0]                  conf_ch_num,
  input  logic [3:0]                  conf_row_num,
  input  logic [3:0]                  conf_pix_num,
  input  logic [bw(PE_NUM/4)-1:0]     conf_grp,
  output logic [ADDR_W-1:0]           dbuf_rd_addr,
  output logic [PE_NUM-1:0]           dbuf_rd_en,
  input  logic [3:0][DDR_W-1:0]       dbuf_rd_data,
  output logic [DDR_W-1:0]            ddr_data,
  output logic                        ddr_valid,
  input  logic                        ddr_ready
);

  localparam int GRP_W = bw(PE_NUM/4);
  localparam int CNT_W = bw(FIFO_DEPTH+1);
  localparam int INF_W = bw(RD_LAT+1);

  dbuf2ddr_state_t   state;

  // Latched pass configuration
  logic              cfg_fc;
  logic [3:0]        cfg_ch;
  logic [3:0]        cfg_row;
  logic [3:0]        cfg_pix;
  logic [GRP_W-1:0]  cfg_grp;

  // Address walker position: row outermost, channel innermost
  logic [3:0]        ch_cnt;
  logic [3:0]        pix_cnt;
  logic [3:0]        row_cnt;

  logic [INF_W-1:0]  inflight;
  logic              issue;
  logic              credit_ok;
  logic              last_rd;
  logic [1:0]        unit;
  logic [ADDR_W-1:0] walk_addr;

  // Read pipe shadow: valid and unit travel RD_LAT cycles with the read
  logic [RD_LAT-1:0] vld_p;
  logic [1:0]        unit_p [RD_LAT];

  logic              fifo_push;
  logic [DDR_W-1:0]  ret_word;
  logic              fifo_pop;
  logic [DDR_W-1:0]  fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic              unused_bits;

  assign unused_bits = ^{conf_mode[3:1], fifo_full};

  assign credit_ok = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
  assign issue     = (state == RUN) && credit_ok;
  // FC latches pix/row limits as zero, so one compare covers both walks.
  assign last_rd   = (ch_cnt == cfg_ch) && (pix_cnt == cfg_pix) && (row_cnt == cfg_row);
  assign unit      = cfg_fc ? 2'd0 : {row_cnt[0], pix_cnt[0]};

  always_comb begin
    walk_addr = '0;
    if (cfg_fc) walk_addr = ADDR_W'(ch_cnt);
    else        walk_addr = {ch_cnt[ADDR_W-5:0], row_cnt[1], pix_cnt[3:1]};
  end

  assign dbuf_rd_addr = issue ? walk_addr : '0;
  assign dbuf_rd_en   = issue ? (PE_NUM'(1) << {cfg_grp, unit}) : '0;
  assign done         = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cfg_fc  <= 1'b0;
      cfg_ch  <= '0;
      cfg_row <= '0;
      cfg_pix <= '0;
      cfg_grp <= '0;
      ch_cnt  <= '0;
      pix_cnt <= '0;
      row_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            cfg_fc  <= conf_mode[0];
            cfg_ch  <= conf_ch_num;
            cfg_row <= conf_mode[0] ? 4'd0 : conf_row_num;
            cfg_pix <= conf_mode[0] ? 4'd0 : conf_pix_num;
            cfg_grp <= conf_grp;
            ch_cnt  <= '0;
            pix_cnt <= '0;
            row_cnt <= '0;
          end
        end
        RUN: begin
          if (issue) begin
            if (last_rd) begin
              state <= DRAIN;
            end else if (ch_cnt != cfg_ch) begin
              ch_cnt <= ch_cnt + 4'd1;
            end else begin
              ch_cnt <= '0;
              if (pix_cnt != cfg_pix) begin
                pix_cnt <= pix_cnt + 4'd1;
              end else begin
                pix_cnt <= '0;
                row_cnt <= row_cnt + 4'd1;
              end
            end
          end
        end
        DRAIN: begin
          // Pipe empty and the very last word leaving the FIFO this cycle.
          if ((inflight == '0) && (fifo_count == CNT_W'(1)) && fifo_pop)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({issue, fifo_push})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // ---- stage p0 .. p(RD_LAT-1): read-pipe shadow ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    unit_p[0] <= unit;
    for (int i = 1; i < RD_LAT; i++) unit_p[i] <= unit_p[i-1];
  end

  // ---- return stage: word arrives, muxed by delayed unit, into FIFO ----
  assign fifo_push = vld_p[RD_LAT-1];
  assign ret_word  = dbuf_rd_data[unit_p[RD_LAT-1]];

  sync_fifo_fwft #(
    .WIDTH (DDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (ret_word),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // ---- output stage: FIFO head drives the DDR channel ----
  assign ddr_valid = !fifo_empty;
  assign ddr_data  = fifo_empty ? '0 : fifo_head;
  assign fifo_pop  = ddr_valid && ddr_ready;

endmodule
